// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
//   arb_state_t   : arbiter FSM states
//   idx_width     : owner index width for n requesters
//   cnt_width     : beat counter width able to hold 0..burst
//   onehot_to_idx : index of the set bit in a one-hot vector
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Widest one-hot vector onehot_to_idx accepts; callers zero-extend to this.
  localparam int unsigned MAXN = 64;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned b);
    return $clog2(b + 1);
  endfunction

  function automatic int unsigned onehot_to_idx(input logic [MAXN-1:0] oh);
    int unsigned idx = 0;
    for (int unsigned i = 0; i < MAXN; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester/FIFO-write bundle for fifo_write_arbiter.
//   slave  : arbiter view (requests and wfull in; ready, write and status out)
//   master : environment view (requesters plus the FIFO write side)
interface fifo_write_arbiter_if #(
  parameter int unsigned nreq  = 4,
  parameter int unsigned dw    = 2,
  parameter int unsigned burst = 4
);
  import fifo_arb_pkg::*;

  localparam int unsigned iw = idx_width(nreq);
  localparam int unsigned bw = cnt_width(burst);

  logic [nreq-1:0]    req_valid;
  logic [nreq*dw-1:0] req_data;
  logic [nreq-1:0]    req_last;
  logic [nreq-1:0]    req_ready;
  logic               fifo_wr;
  logic [dw-1:0]      fifo_wdata;
  logic               fifo_wfull;
  logic [nreq-1:0]    grant;
  logic [iw-1:0]      owner_id;
  logic [bw-1:0]      beat_cnt;
  logic               busy;

  modport slave (
    input  req_valid, req_data, req_last, fifo_wfull,
    output req_ready, fifo_wr, fifo_wdata, grant, owner_id, beat_cnt, busy
  );

  modport master (
    output req_valid, req_data, req_last, fifo_wfull,
    input  req_ready, fifo_wr, fifo_wdata, grant, owner_id, beat_cnt, busy
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of valid_i searching
// circularly from last_i+1.
//   valid_i    : request vector
//   last_i     : index of the previous owner (lowest priority)
//   pick_o     : one-hot winner, zero when nothing is valid
//   pick_idx_o : index of the winner
//   any_o      : at least one request is valid
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int unsigned nreq = 4,
  parameter int unsigned iw   = 2
) (
  input  logic [nreq-1:0] valid_i,
  input  logic [iw-1:0]   last_i,
  output logic [nreq-1:0] pick_o,
  output logic [iw-1:0]   pick_idx_o,
  output logic            any_o
);

  always_comb begin
    pick_o = '0;
    any_o  = 1'b0;
    // k = nreq wraps back to last_i itself, so it has the lowest priority.
    for (int unsigned k = 1; k <= nreq; k++) begin
      int unsigned idx;
      idx = (32'(last_i) + k) % nreq;
      if (!any_o && valid_i[iw'(idx)]) begin
        pick_o[iw'(idx)] = 1'b1;
        any_o            = 1'b1;
      end
    end
    pick_idx_o = iw'(onehot_to_idx(MAXN'(pick_o)));
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among nreq packet sources.
// A grant is held until end-of-packet or burst beats, with one arbitration
// cycle between grants.
//   wclk, wrst : write-domain clock, asynchronous active-high reset
//   bus        : requester handshakes, FIFO write/wfull, grant status
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned nreq  = 4,
  parameter int unsigned dw    = 2,
  parameter int unsigned burst = 4
) (
  input  logic                  wclk,
  input  logic                  wrst,
  fifo_write_arbiter_if.slave   bus
);

  localparam int unsigned iw = idx_width(nreq);
  localparam int unsigned bw = cnt_width(burst);

  arb_state_t      state_q;
  logic [nreq-1:0] grant_q;
  logic [iw-1:0]   owner_q;
  logic [bw-1:0]   cnt_q;
  logic            busy_q;

  logic [nreq-1:0] pick;
  logic [iw-1:0]   pick_idx;
  logic            pick_any;

  logic            granted_c;
  logic            wr_c;
  logic            release_c;
  logic [dw-1:0]   wdata_c;

  rr_picker #(
    .nreq (nreq),
    .iw   (iw)
  ) u_picker (
    .valid_i    (bus.req_valid),
    .last_i     (owner_q),
    .pick_o     (pick),
    .pick_idx_o (pick_idx),
    .any_o      (pick_any)
  );

  // Owner handshake; wfull gates both ready and write in the same cycle.
  always_comb begin
    wdata_c = '0;
    for (int unsigned i = 0; i < nreq; i++) begin
      if (owner_q == iw'(i)) wdata_c = bus.req_data[i*dw +: dw];
    end
    granted_c = (state_q == ARB_GRANT);
    wr_c      = granted_c & bus.req_valid[owner_q] & ~bus.fifo_wfull;
    // Last beat and burst limit on the same beat still release only once.
    release_c = wr_c & (bus.req_last[owner_q] | (cnt_q == bw'(burst - 1)));
  end

  assign bus.req_ready  = (granted_c && !bus.fifo_wfull) ? grant_q : '0;
  assign bus.fifo_wr    = wr_c;
  assign bus.fifo_wdata = wdata_c;
  assign bus.grant      = grant_q;
  assign bus.owner_id   = owner_q;
  assign bus.beat_cnt   = cnt_q;
  assign bus.busy       = busy_q;

  // Arbitration FSM; owner_q survives release so the last owner ranks lowest.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      owner_q <= iw'(nreq - 1);
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            state_q <= ARB_GRANT;
            grant_q <= pick;
            owner_q <= pick_idx;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ARB_GRANT: begin
          if (release_c) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (wr_c) begin
            cnt_q <= cnt_q + bw'(1);
          end
        end
        default: begin
          state_q <= ARB_IDLE;
          grant_q <= '0;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter (nreq=4, dw=2, burst=4).
module tb_fifo_write_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned DW    = 2;
  localparam int unsigned BURST = 4;

  logic wclk;
  logic wrst;

  fifo_write_arbiter_if #(.nreq(NREQ), .dw(DW), .burst(BURST)) bus ();

  fifo_write_arbiter #(.nreq(NREQ), .dw(DW), .burst(BURST)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_wr    = 0;
  int w0      = 0;
  logic [DW-1:0] wlog[$];

  // Count FIFO writes seen at each edge.
  always @(posedge wclk) begin
    if (!wrst && bus.fifo_wr) begin
      n_wr++;
      wlog.push_back(bus.fifo_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge wclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_data(input int unsigned idx, input logic [DW-1:0] val);
    bus.req_data[idx*DW +: DW] = val;
  endtask

  logic [NREQ-1:0] exp_g [5];
  int unsigned     exp_i [5];

  initial begin
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_i = '{0, 1, 2, 3, 0};

    wrst           = 1'b1;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.req_last   = '0;
    bus.fifo_wfull = 1'b0;
    #2;
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_owner", 32'(bus.owner_id), 3);
    chk("rst_cnt", 32'(bus.beat_cnt), 0);
    chk("rst_wr", 32'(bus.fifo_wr), 0);
    chk("rst_ready", 32'(bus.req_ready), 0);
    cyc(); cyc();
    wrst = 1'b0;

    // Round robin, all valid, no req_last: burst limit ends every grant.
    for (int i = 0; i < 4; i++) set_data(i, DW'(i));
    bus.req_valid = 4'hF;
    settle();
    chk("rr_idle", 32'(bus.grant), 0);
    for (int g = 0; g < 5; g++) begin
      w0 = n_wr;
      cyc(); settle();
      chk("rr_grant", 32'(bus.grant), 32'(exp_g[g]));
      chk("rr_owner", 32'(bus.owner_id), exp_i[g]);
      for (int b = 0; b < 4; b++) begin
        chk("rr_wr", 32'(bus.fifo_wr), 1);
        chk("rr_wdata", 32'(bus.fifo_wdata), exp_i[g]);
        chk("rr_cnt", 32'(bus.beat_cnt), 32'(b));
        cyc(); settle();
      end
      chk("rr_release", 32'(bus.grant), 0);
      chk("rr_nwr", 32'(n_wr - w0), 4);
    end
    bus.req_valid = '0;
    cyc(); settle();
    chk("rr_quiet", 32'(bus.grant), 0);

    // Reset mid-grant while a beat is being written.
    bus.req_valid = 4'hF;
    cyc(); settle();
    chk("rmid_grant", 32'(bus.grant), 32'(4'b0010));
    chk("rmid_wr", 32'(bus.fifo_wr), 1);
    cyc(); settle();
    chk("rmid_cnt", 32'(bus.beat_cnt), 1);
    chk("rmid_wr2", 32'(bus.fifo_wr), 1);
    w0 = n_wr;
    wrst = 1'b1;
    settle();
    chk("rmid_rgrant", 32'(bus.grant), 0);
    chk("rmid_rwr", 32'(bus.fifo_wr), 0);
    chk("rmid_rready", 32'(bus.req_ready), 0);
    chk("rmid_rbusy", 32'(bus.busy), 0);
    chk("rmid_rcnt", 32'(bus.beat_cnt), 0);
    chk("rmid_rowner", 32'(bus.owner_id), 3);
    cyc(); cyc();
    chk("rmid_nwr", 32'(n_wr - w0), 0);
    wrst = 1'b0;
    cyc(); settle();
    chk("rmid_first", 32'(bus.grant), 32'(4'b0001));
    bus.req_last = 4'b0001;
    settle();
    chk("rmid_lastwr", 32'(bus.fifo_wr), 1);
    cyc(); settle();
    chk("rmid_rel", 32'(bus.grant), 0);
    bus.req_valid = '0;
    bus.req_last  = '0;

    // Single three-beat packet from requester 1.
    bus.req_valid = 4'b0010;
    set_data(1, 2'd1);
    settle();
    chk("pkt_lat", 32'(bus.grant), 0);
    w0 = n_wr;
    cyc(); settle();
    chk("pkt_grant", 32'(bus.grant), 32'(4'b0010));
    chk("pkt_busy", 32'(bus.busy), 1);
    chk("pkt_wr", 32'(bus.fifo_wr), 1);
    chk("pkt_wd1", 32'(bus.fifo_wdata), 1);
    chk("pkt_ready", 32'(bus.req_ready), 32'(4'b0010));
    cyc(); set_data(1, 2'd2); settle();
    chk("pkt_cnt1", 32'(bus.beat_cnt), 1);
    chk("pkt_wd2", 32'(bus.fifo_wdata), 2);
    cyc(); set_data(1, 2'd3); bus.req_last = 4'b0010; settle();
    chk("pkt_wr3", 32'(bus.fifo_wr), 1);
    cyc(); bus.req_valid = '0; bus.req_last = '0; settle();
    chk("pkt_relgrant", 32'(bus.grant), 0);
    chk("pkt_relbusy", 32'(bus.busy), 0);
    chk("pkt_owner", 32'(bus.owner_id), 1);
    chk("pkt_relcnt", 32'(bus.beat_cnt), 0);
    chk("pkt_nwr", 32'(n_wr - w0), 3);
    chk("pkt_log1", 32'(wlog[wlog.size()-3]), 1);
    chk("pkt_log2", 32'(wlog[wlog.size()-2]), 2);
    chk("pkt_log3", 32'(wlog[wlog.size()-1]), 3);

    // Backpressure: wfull for two cycles after beat 2 of requester 2.
    bus.req_valid = 4'b0100;
    set_data(2, 2'd3);
    cyc(); settle();
    chk("bp_grant", 32'(bus.grant), 32'(4'b0100));
    w0 = n_wr;
    cyc(); settle();
    cyc(); settle();
    chk("bp_cnt2", 32'(bus.beat_cnt), 2);
    bus.fifo_wfull = 1'b1;
    settle();
    chk("bp_wr0", 32'(bus.fifo_wr), 0);
    chk("bp_ready0", 32'(bus.req_ready), 0);
    cyc(); settle();
    chk("bp_wr1", 32'(bus.fifo_wr), 0);
    chk("bp_hold", 32'(bus.beat_cnt), 2);
    chk("bp_ghold", 32'(bus.grant), 32'(4'b0100));
    cyc(); bus.fifo_wfull = 1'b0; settle();
    chk("bp_hold2", 32'(bus.beat_cnt), 2);
    chk("bp_resume", 32'(bus.fifo_wr), 1);
    cyc(); settle();
    chk("bp_cnt3", 32'(bus.beat_cnt), 3);
    cyc(); settle();
    chk("bp_rel", 32'(bus.grant), 0);
    chk("bp_nwr", 32'(n_wr - w0), 4);
    bus.req_valid = '0;

    // Owner 1 stalls mid-packet while requester 2 waits.
    bus.req_valid = 4'b0110;
    set_data(1, 2'd2);
    cyc(); settle();
    chk("st_grant", 32'(bus.grant), 32'(4'b0010));
    cyc();
    bus.req_valid = 4'b0100;
    w0 = n_wr;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("st_hold", 32'(bus.grant), 32'(4'b0010));
      chk("st_nowr", 32'(bus.fifo_wr), 0);
      cyc();
    end
    chk("st_nwr", 32'(n_wr - w0), 0);
    bus.req_valid = 4'b0110;
    bus.req_last  = 4'b0010;
    settle();
    chk("st_lastwr", 32'(bus.fifo_wr), 1);
    chk("st_wdata", 32'(bus.fifo_wdata), 2);
    cyc(); settle();
    chk("st_rel", 32'(bus.grant), 0);
    bus.req_last  = '0;
    bus.req_valid = 4'b0100;
    cyc(); settle();
    chk("st_next", 32'(bus.grant), 32'(4'b0100));
    bus.req_last = 4'b0100;
    cyc(); bus.req_valid = '0; bus.req_last = '0; settle();
    chk("st_done", 32'(bus.grant), 0);

    // Last beat coincides with the burst limit: one release.
    bus.req_valid = 4'b1001;
    set_data(3, 2'd1);
    cyc(); settle();
    chk("co_grant", 32'(bus.grant), 32'(4'b1000));
    w0 = n_wr;
    for (int b = 0; b < 4; b++) begin
      if (b == 3) bus.req_last = 4'b1000;
      settle();
      chk("co_wr", 32'(bus.fifo_wr), 1);
      chk("co_cnt", 32'(bus.beat_cnt), 32'(b));
      cyc();
    end
    settle();
    chk("co_rel", 32'(bus.grant), 0);
    chk("co_relcnt", 32'(bus.beat_cnt), 0);
    chk("co_busy", 32'(bus.busy), 0);
    chk("co_nwr", 32'(n_wr - w0), 4);
    chk("co_owner", 32'(bus.owner_id), 3);
    bus.req_last = '0;
    cyc(); settle();
    chk("co_next", 32'(bus.grant), 32'(4'b0001));
    bus.req_valid = '0;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
